// File: rtl/csa_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csa_mult_pkg
// Purpose  : Shared defaults and helper functions for the pipelined
//            carry-save multiplier (csa_mult_pipe / csa_row).
// Contents : DEFAULT_WIDTH, DEFAULT_ROWS   - parameter defaults
//            mult_latency(width, rows)     - input-to-output latency in cycles
//            bw_corr(width, row)           - Baugh-Wooley correction bit that
//                                            a given row injects
// Revision : 1.0 - initial release
// ============================================================================
package csa_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_ROWS  = 2;

  // Operand register + one register per ROWS group + carry-propagate register.
  function automatic int mult_latency(input int width, input int rows);
    return (width / rows) + 2;
  endfunction

  // Signed products need +2^W and +2^(2W-1). Row j's freed top sum bit has
  // weight W+j, so row 0 supplies 2^W and row W-1 supplies 2^(2W-1).
  function automatic logic bw_corr(input int width, input int row);
    return (row == 0) || (row == width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_row.sv
`default_nettype none
// ============================================================================
// Module   : csa_row
// Purpose  : One WIDTH-bit row of full adders of a carry-save array
//            multiplier. Adds one partial-product row into the running
//            sum/carry vectors and retires the lowest sum bit.
// Ports    : sum_prev   [WIDTH] - running sum, bit i has weight i+j
//            carry_prev [WIDTH] - running carry, bit i has weight i+j
//            pp         [WIDTH] - partial-product row j, bit i weight i+j
//            fill       [1]     - value for the vacated top sum bit
//            sum_next   [WIDTH] - sum realigned to row j+1
//            carry_next [WIDTH] - carries, already aligned to row j+1
//            lsb        [1]     - finished product bit j
// Revision : 1.0 - initial release
// ============================================================================
module csa_row
  import csa_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] sum_prev,
  input  logic [WIDTH-1:0] carry_prev,
  input  logic [WIDTH-1:0] pp,
  input  logic             fill,
  output logic [WIDTH-1:0] sum_next,
  output logic [WIDTH-1:0] carry_next,
  output logic             lsb
);

  logic [WIDTH-1:0] fa_sum;

  assign fa_sum     = sum_prev ^ carry_prev ^ pp;
  assign carry_next = (sum_prev & carry_prev) | (sum_prev & pp) | (carry_prev & pp);

  // Sum bits shift down one place to match the next row's weight; the top
  // position is empty unless a correction constant is injected there.
  assign sum_next = {fill, fa_sum[WIDTH-1:1]};
  assign lsb      = fa_sum[0];

endmodule
`default_nettype wire

// File: rtl/csa_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : csa_mult_pipe
// Purpose  : Pipelined carry-save array multiplier with valid/ready handshake.
//            Operand register -> WIDTH/ROWS carry-save stages (ROWS rows each)
//            -> ripple carry-propagate stage registered into y.
//            A single enable stalls the whole pipe when y is not consumed.
// Ports    : clk, rst_n (async, active low)
//            in_valid / in_ready, a, b [WIDTH], sgn  - operand side
//            out_valid / out_ready, y [2*WIDTH]      - result side
// Config   : CSA_MULT_SIGNED_EN - when defined, sgn=1 selects a two's
//            complement (Baugh-Wooley) product; otherwise sgn is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module csa_mult_pipe
  import csa_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ROWS  = DEFAULT_ROWS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y
);

  localparam int STAGES = WIDTH / ROWS;

  logic en;
  logic sgn_in;
  logic unused_bits;

  // Boundary signals between stages: index k feeds carry-save stage k.
  logic [WIDTH-1:0] pipe_s   [0:STAGES];
  logic [WIDTH-1:0] pipe_c   [0:STAGES];
  logic [WIDTH-1:0] pipe_lo  [0:STAGES];
  logic             pipe_vld [0:STAGES];
  logic [WIDTH-1:0] pipe_a   [0:STAGES-1];
  logic [WIDTH-1:0] pipe_b   [0:STAGES-1];
  logic             pipe_sgn [0:STAGES-1];

  // Only an unconsumed result blocks progress; bubbles travel like data.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

`ifdef CSA_MULT_SIGNED_EN
  assign sgn_in = sgn;
`else
  assign sgn_in = 1'b0;
`endif

  // Last stage only needs the top multiplier bits; sgn is unread when the
  // signed option is compiled out.
  assign unused_bits = ^{sgn, pipe_b[STAGES-1]};

  // --------------------------------------------------------------------------
  // Operand register stage
  // --------------------------------------------------------------------------
  logic             op_vld;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sgn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld <= 1'b0;
    end else if (en) begin
      op_vld <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      op_a   <= a;
      op_b   <= b;
      op_sgn <= sgn_in;
    end
  end

  assign pipe_vld[0] = op_vld;
  assign pipe_a[0]   = op_a;
  assign pipe_b[0]   = op_b;
  assign pipe_sgn[0] = op_sgn;
  assign pipe_s[0]   = '0;
  assign pipe_c[0]   = '0;
  assign pipe_lo[0]  = '0;

  // --------------------------------------------------------------------------
  // Carry-save stages, ROWS full-adder rows each
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] row_s [0:ROWS];
    logic [WIDTH-1:0] row_c [0:ROWS];
    logic [ROWS-1:0]  row_lsb;
    logic [WIDTH-1:0] lo_next;
    logic             vld_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] lo_q;

    assign row_s[0] = pipe_s[k];
    assign row_c[0] = pipe_c[k];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam int J = k * ROWS + r;
      // Baugh-Wooley: invert terms pairing exactly one sign bit. Row W-1
      // inverts all but a[W-1]*b[W-1]; other rows invert only a[W-1]*b[j].
      localparam logic [WIDTH-1:0] INV_MASK = (J == WIDTH - 1) ?
                                              {1'b0, {(WIDTH-1){1'b1}}} :
                                              {1'b1, {(WIDTH-1){1'b0}}};
      localparam logic CORR = bw_corr(WIDTH, J);

      logic [WIDTH-1:0] pp;

      assign pp = (pipe_a[k] & {WIDTH{pipe_b[k][J]}}) ^
                  (INV_MASK & {WIDTH{pipe_sgn[k]}});

      csa_row #(
        .WIDTH (WIDTH)
      ) u_row (
        .sum_prev   (row_s[r]),
        .carry_prev (row_c[r]),
        .pp         (pp),
        .fill       (pipe_sgn[k] & CORR),
        .sum_next   (row_s[r+1]),
        .carry_next (row_c[r+1]),
        .lsb        (row_lsb[r])
      );
    end

    // Retired bits drop into their final slot of the low product half.
    always_comb begin
      lo_next                 = pipe_lo[k];
      lo_next[k*ROWS +: ROWS] = row_lsb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
      end else if (en) begin
        vld_q <= pipe_vld[k];
      end
    end

    always_ff @(posedge clk) begin
      if (en) begin
        s_q  <= row_s[ROWS];
        c_q  <= row_c[ROWS];
        lo_q <= lo_next;
      end
    end

    assign pipe_vld[k+1] = vld_q;
    assign pipe_s[k+1]   = s_q;
    assign pipe_c[k+1]   = c_q;
    assign pipe_lo[k+1]  = lo_q;

    // Operands and mode only travel as far as a later stage still needs them.
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             sgn_q;

      always_ff @(posedge clk) begin
        if (en) begin
          a_q   <= pipe_a[k];
          b_q   <= pipe_b[k];
          sgn_q <= pipe_sgn[k];
        end
      end

      assign pipe_a[k+1]   = a_q;
      assign pipe_b[k+1]   = b_q;
      assign pipe_sgn[k+1] = sgn_q;
    end
  end

  // --------------------------------------------------------------------------
  // Carry-propagate stage: ripple add of the final sum/carry gives the upper
  // half; its carry-out is beyond 2*WIDTH and is dropped.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] hi;

  always_comb begin : ripple
    logic rc;
    hi = '0;
    rc = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      hi[i] = pipe_s[STAGES][i] ^ pipe_c[STAGES][i] ^ rc;
      rc    = (pipe_s[STAGES][i] & pipe_c[STAGES][i]) |
              (rc & (pipe_s[STAGES][i] ^ pipe_c[STAGES][i]));
    end
  end

  // y only loads real results, so unreset datapath contents never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (en) begin
      out_valid <= pipe_vld[STAGES];
      if (pipe_vld[STAGES]) begin
        y <= {hi, pipe_lo[STAGES]};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csa_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_mult_pipe
// Purpose  : Self-checking bench for csa_mult_pipe (WIDTH=8, ROWS=2).
//            Expected products come from a behavioural multiply and are
//            queued at each input transfer, then compared in order at each
//            output transfer.
// Config   : CSA_MULT_SIGNED_EN - selects the signed reference for sgn=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_mult_pipe;

`ifdef CSA_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  csa_mult_pipe #(
    .WIDTH (8),
    .ROWS  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  function automatic logic [15:0] ref_mult(input logic [7:0] x, input logic [7:0] z,
                                           input logic s);
    logic signed [15:0] sx;
    logic signed [15:0] sz;
    sx = {{8{x[7]}}, x};
    sz = {{8{z[7]}}, z};
    if (s && SIGNED_EN) ref_mult = 16'(sx * sz);
    else                ref_mult = {8'h00, x} * {8'h00, z};
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 8'hAA; b = 8'h55; sgn = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (y !== 16'h0000) begin miscompares++; $display("FAIL reset_y: got %h want 0000", y); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    advance();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    advance();
  endtask

  task automatic test_directed();
    logic [7:0]  ta [5];
    logic [7:0]  tb [5];
    logic        ts [5];
    logic [15:0] te [5];
    int n;
    ta = '{8'hFF, 8'h00, 8'h80, 8'hFF, 8'hFF};
    tb = '{8'hFF, 8'd77, 8'h80, 8'h01, 8'h01};
    ts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    te = '{16'hFE01, 16'h0000, 16'h4000, SIGNED_EN ? 16'hFFFF : 16'h00FF, 16'h00FF};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = ta[i]; b = tb[i]; sgn = ts[i];
      n = 0;
      do begin
        @(posedge clk);
        n++;
        #1 in_valid = 1'b0;
        @(negedge clk);
      end while (!out_valid && n < 20);
      vectors++;
      if (n != 6) begin miscompares++; $display("FAIL directed_latency[%0d]: got %0d want 6", i, n); end
      vectors++;
      if (y !== te[i]) begin miscompares++; $display("FAIL directed_y[%0d]: got %h want %h", i, y, te[i]); end
    end
    advance();
  endtask

  task automatic test_stream();
    int sent = 0, got = 0, first = -1, last = -1, cyc = 0;
    logic [15:0] e;
    exp_q.delete();
    out_ready = 1'b1;
    while ((sent < 16 || exp_q.size() != 0) && cyc < 100) begin
      in_valid = (sent < 16); a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
      @(negedge clk);
      if (out_valid && out_ready) begin
        vectors++; got++;
        if (first < 0) first = cyc;
        last = cyc;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL stream_extra: got %h want none", y); end
        else begin
          e = exp_q.pop_front();
          if (y !== e) begin miscompares++; $display("FAIL stream_data: got %h want %h", y, e); end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_mult(a, b, sgn)); sent++; end
      advance(); cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 16) begin miscompares++; $display("FAIL stream_count: got %0d want 16", got); end
    vectors++;
    if (last - first != 15) begin miscompares++; $display("FAIL stream_gapless: got span %0d want 15", last - first); end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, cyc = 0, stall_left = -1;
    logic [15:0] held = '0;
    logic [15:0] e;
    exp_q.delete();
    while ((sent < 12 || exp_q.size() != 0) && cyc < 200) begin
      if (stall_left < 0 && out_valid) begin stall_left = 5; held = y; end
      out_ready = !(stall_left > 0);
      in_valid = (sent < 12); a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
      @(negedge clk);
      if (stall_left > 0) begin
        vectors++;
        if (y !== held) begin miscompares++; $display("FAIL bp_hold_y: got %h want %h", y, held); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        stall_left--;
      end
      if (out_valid && out_ready) begin
        vectors++; got++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL bp_extra: got %h want none", y); end
        else begin
          e = exp_q.pop_front();
          if (y !== e) begin miscompares++; $display("FAIL bp_data: got %h want %h", y, e); end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_mult(a, b, sgn)); sent++; end
      advance(); cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (got != 12 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL bp_count: got %0d left %0d want 12 left 0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
      advance();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    advance();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale[%0d]: got out_valid %b y %h want 0", i, out_valid, y); end
      advance();
    end
    in_valid = 1'b1; a = 8'd13; b = 8'd11; sgn = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1 in_valid = 1'b0;
      @(negedge clk);
    end while (!out_valid && n < 20);
    vectors++;
    if (n != 6) begin miscompares++; $display("FAIL mid_latency: got %0d want 6", n); end
    vectors++;
    if (y !== 16'h008F) begin miscompares++; $display("FAIL mid_y: got %h want 008f", y); end
    advance();
  endtask

  task automatic test_mixed();
    int cyc = 0;
    logic [15:0] e;
    exp_q.delete();
    while ((cyc < 300 || exp_q.size() != 0) && cyc < 500) begin
      in_valid  = (cyc < 300) && ($urandom_range(3) != 0);
      out_ready = (cyc >= 300) || ($urandom_range(3) != 0);
      a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
      @(negedge clk);
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL mixed_extra: got %h want none", y); end
        else begin
          e = exp_q.pop_front();
          if (y !== e) begin miscompares++; $display("FAIL mixed_data: got %h want %h", y, e); end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_mult(a, b, sgn));
      advance(); cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL mixed_drain: got %0d left want 0", exp_q.size()); end
  endtask

  // Every a,b pair once; sgn alternates with the operand LSBs so both modes
  // see a large share of the space within a single sweep.
  task automatic test_exhaustive();
    int idx = 0, cyc = 0;
    logic [15:0] pair;
    logic [15:0] e;
    exp_q.delete();
    out_ready = 1'b1;
    while ((idx < 65536 || exp_q.size() != 0) && cyc < 70000) begin
      pair = 16'(idx);
      in_valid = (idx < 65536); a = pair[15:8]; b = pair[7:0]; sgn = pair[8] ^ pair[0];
      @(negedge clk);
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL exh_extra: got %h want none", y); end
        else begin
          e = exp_q.pop_front();
          if (y !== e) begin miscompares++; $display("FAIL exh_data: got %h want %h", y, e); end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_mult(a, b, sgn)); idx++; end
      advance(); cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (idx != 65536 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL exh_complete: got %0d sent %0d left want 65536 sent 0 left", idx, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_mixed();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/csa_mult_pipe.md
CSA_MULT_PIPE -- requirements
Module: csa_mult_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter ROWS, default 2, giving the carry-save rows per pipeline stage; WIDTH SHALL be an integer multiple of ROWS.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands are presented this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the operands this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the multiplicand and multiplier.
REQ-008 The block SHALL have port sgn, input, 1 bit: 1 means treat a and b as two's complement; it is sampled with the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: y holds a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts y.
REQ-011 The block SHALL have port y, output, 2*WIDTH bits: the product.

Function
REQ-012 A transfer SHALL occur on the input side when in_valid and in_ready are both 1, and on the output side when out_valid and out_ready are both 1.
REQ-013 The pipeline SHALL be: one operand register stage, then S = WIDTH/ROWS carry-save stages, then one carry-propagate stage.
REQ-014 The carry-save stages SHALL hold sum and carry vectors plus finished low product bits; each stage reduces ROWS partial-product rows.
REQ-015 The carry-propagate stage SHALL produce the upper WIDTH bits by a ripple add of the final sum and carry, and SHALL register the result into y.
REQ-016 Latency SHALL be L = S + 2 cycles from the input transfer to out_valid=1, when there is no stall.
REQ-017 The block SHALL accept one operation per cycle with no bubbles while out_ready=1.
REQ-018 Stall rule: a global enable en = !(out_valid && !out_ready) SHALL gate every pipeline register, including the valid bits.
REQ-019 in_ready SHALL equal en and SHALL be combinational from out_valid and out_ready only.
REQ-020 While stalled, y and out_valid SHALL hold their values, and no input SHALL be accepted.
REQ-021 Each stage SHALL carry a valid bit; stages with valid=0 SHALL still advance when en=1, so bubbles collapse only at the output.
REQ-022 Unsigned mode (sgn=0) SHALL give y = a*b exactly, mod 2^(2*WIDTH), with no overflow possible.
REQ-023 Results SHALL leave in input order.
REQ-024 The sgn bit SHALL travel with its operands; mixed-mode back-to-back traffic SHALL be correct.
REQ-025 Simultaneous output drain and input accept in one cycle SHALL both occur.

Reset
REQ-026 When rst_n=0, all valid bits SHALL clear immediately, out_valid SHALL be 0, and y SHALL be 0.
REQ-027 When rst_n=0, in_ready SHALL be 1.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; no result from before reset SHALL ever appear.
REQ-029 Datapath registers other than y SHALL need no reset, but the bench SHALL check that their X values never reach y while out_valid=1.

Configuration
REQ-030 With macro CSA_MULT_SIGNED_EN defined, sgn=1 SHALL give the two's-complement product (Baugh-Wooley: inverted MSB partial-product terms plus correction constants in the first and last rows).
REQ-031 Without CSA_MULT_SIGNED_EN, the sgn port SHALL remain present but SHALL be ignored, and every operation SHALL be unsigned.
REQ-032 Latency SHALL be identical with and without CSA_MULT_SIGNED_EN.

Structure
REQ-033 A package csa_mult_pkg SHALL hold function mult_latency(WIDTH, ROWS), the parameter defaults, and the Baugh-Wooley correction constant function.
REQ-034 One sub-module csa_row SHALL implement one WIDTH-bit row of full adders (inputs sum, carry and partial product; outputs sum, carry and the finished LSB).
REQ-035 csa_row SHALL be instantiated WIDTH times through generate.
REQ-036 Stage registers SHALL be generated per ROWS group.

Verification (WIDTH=8, ROWS=2, L=6)
REQ-037 Unsigned: a=255, b=255, sgn=0 -> y=0xFE01 exactly 6 cycles after the transfer; a=0, b=77 -> y=0x0000.
REQ-038 Signed, with CSA_MULT_SIGNED_EN: a=0x80, b=0x80, sgn=1 -> y=0x4000; a=0xFF, b=0x01, sgn=1 -> y=0xFFFF; the same a=0xFF, b=0x01 with sgn=0 -> y=0x00FF.
REQ-039 Streaming: 16 back-to-back random transfers with out_ready=1 -> 16 consecutive out_valid cycles, in order, all products correct.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles while a result is valid -> y stable, in_ready=0, and after release no result is lost or duplicated.
REQ-041 Reset mid-flight: assert rst_n=0 for 1 cycle while 3 operations are in flight -> out_valid stays 0 until a new operand enters, whose result then appears after 6 cycles.
REQ-042 Exhaustive: all 65536 a,b pairs per mode, compared against a reference model.
